// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundles the signals exchanged between the pipeline datapath and the
//   sequencing controller. The clock and reset stay outside this interface.
//
//   Datapath -> controller:
//     id_rs, id_rs_use, id_rt, id_rt_use   source registers read by the D instruction
//     ex_load, ex_rd                       load in E and its destination register
//     id_md_use                            D instruction touches HI/LO or the md unit
//     ex_md_start, ex_md_div               E starts a multiply (0) or a divide (1)
//     m_exc, m_exc_code                    exception/interrupt taken in M, and its ExcCode
//     m_eret, epc                          ERET in M, and the current CP0 EPC
//   Controller -> datapath:
//     freeze_pc, freeze_ifid, bubble_idex  stall controls
//     flush_pipe                           clears IF/ID, ID/EX and EX/MEM
//     pc_redirect, redirect_target         PC load enable and its value
//     md_busy                              multiply/divide unit busy
//     exc_code_q                           ExcCode latched at exception entry
//
//   Modports:
//     master  the datapath side (drives the hazard inputs)
//     slave   the controller side (pipe_ctrl)
interface pipe_ctrl_if;
  logic [4:0]  id_rs;
  logic        id_rs_use;
  logic [4:0]  id_rt;
  logic        id_rt_use;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        id_md_use;
  logic        ex_md_start;
  logic        ex_md_div;
  logic        m_exc;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic [31:0] epc;

  logic        freeze_pc;
  logic        freeze_ifid;
  logic        bubble_idex;
  logic        flush_pipe;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        md_busy;
  logic [4:0]  exc_code_q;

  modport master (
    output id_rs, id_rs_use, id_rt, id_rt_use, ex_load, ex_rd,
           id_md_use, ex_md_start, ex_md_div,
           m_exc, m_exc_code, m_eret, epc,
    input  freeze_pc, freeze_ifid, bubble_idex, flush_pipe,
           pc_redirect, redirect_target, md_busy, exc_code_q
  );

  modport slave (
    input  id_rs, id_rs_use, id_rt, id_rt_use, ex_load, ex_rd,
           id_md_use, ex_md_start, ex_md_div,
           m_exc, m_exc_code, m_eret, epc,
    output freeze_pc, freeze_ifid, bubble_idex, flush_pipe,
           pc_redirect, redirect_target, md_busy, exc_code_q
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline sequencing controller for the 5-stage MIPS core. It produces
//   the freeze/clear controls of the stage registers and the PC redirect by
//   combining three mechanisms:
//     - load-use hazard stalls (combinational),
//     - multiply/divide busy stalls driven by an internal down-counter,
//     - a RUN -> FLUSH -> REFILL sequencer for exception entry and ERET.
//
//   Ports:
//     CLK    rising-edge clock
//     reset  asynchronous, active-low (0 = reset asserted)
//     bus    pipe_ctrl_if.slave, all hazard inputs and control outputs
//
//   Parameters:
//     MULT_CYCLES   busy cycles after a MULT/MULTU issues from E
//     DIV_CYCLES    busy cycles after a DIV/DIVU issues from E
//     HANDLER_ADDR  exception handler entry PC
module pipe_ctrl #(
  parameter int unsigned MULT_CYCLES  = 5,
  parameter int unsigned DIV_CYCLES   = 10,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic       CLK,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] md_count;
  logic             flush_q;
  logic             redirect_q;
  logic [31:0]      target_q;
  logic [4:0]       code_q;

  logic             md_busy_int;
  logic             rs_hit;
  logic             rt_hit;
  logic             load_use;
  logic             md_hazard;
  logic             stall;

  // Multiply/divide busy counter. A start is only honoured when the unit is
  // idle; a start while busy cannot happen in a correct pipeline because the
  // md stall holds the dependent instruction, so it is simply ignored here.
  // The counter keeps running through FLUSH/REFILL so an issued operation
  // always completes.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      md_count <= '0;
    end else if (md_count == '0) begin
      if (bus.ex_md_start) begin
        md_count <= bus.ex_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end
    end else begin
      md_count <= md_count - CNT_W'(1);
    end
  end

  assign md_busy_int = (md_count != '0);

  // Exception/ERET sequencer. FLUSH and REFILL each last one cycle. The flush
  // and redirect strobes are registered so they are glitch-free and line up
  // with the FLUSH state. Exceptions win over ERET when both are seen; in
  // REFILL the M stage holds a bubble, so m_exc/m_eret are not looked at.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      code_q     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.m_exc) begin
            state      <= FLUSH;
            flush_q    <= 1'b1;
            redirect_q <= 1'b1;
            target_q   <= HANDLER_ADDR;
            code_q     <= bus.m_exc_code;
          end else if (bus.m_eret) begin
            state      <= FLUSH;
            flush_q    <= 1'b1;
            redirect_q <= 1'b1;
            target_q   <= bus.epc;
          end
        end
        FLUSH: begin
          state      <= REFILL;
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
        end
        REFILL: begin
          state <= RUN;
        end
        default: begin
          state      <= RUN;
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall detection. Register $0 never creates a load-use hazard. The md
  // hazard also covers the issue cycle itself (ex_md_start), before the
  // counter has been loaded. The flush overrides any freeze, and the reset
  // term keeps the combinational outputs low while reset is held.
  always_comb begin
    rs_hit    = bus.id_rs_use && (bus.id_rs == bus.ex_rd);
    rt_hit    = bus.id_rt_use && (bus.id_rt == bus.ex_rd);
    load_use  = bus.ex_load && (bus.ex_rd != 5'd0) && (rs_hit || rt_hit);
    md_hazard = bus.id_md_use && (md_busy_int || bus.ex_md_start);
    stall     = (load_use || md_hazard) && (state != FLUSH) && reset;
  end

  assign bus.freeze_pc       = stall;
  assign bus.freeze_ifid     = stall;
  assign bus.bubble_idex     = stall;
  assign bus.flush_pipe      = flush_q;
  assign bus.pc_redirect     = redirect_q;
  assign bus.redirect_target = target_q;
  assign bus.md_busy         = md_busy_int;
  assign bus.exc_code_q      = code_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the freeze and clear controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC redirect.
- Combines three mechanisms: load-use hazard stalls, multiply/divide busy stalls (internal cycle counter), and a small FSM that sequences exception entry and ERET return (flush, redirect, one refill cycle).
- Sits beside the hazard-detection logic in the top level; its outputs feed the FREEZE and reset-style clear inputs of the stage registers.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU after issue from EX
- DIV_CYCLES, 10, busy cycles for DIV/DIVU after issue from EX
- HANDLER_ADDR, 32'h0000_4180, exception handler entry PC

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- id_rs  in  5  rs field of the instruction in D
- id_rs_use  in  1  D instruction reads rs
- id_rt  in  5  rt field of the instruction in D
- id_rt_use  in  1  D instruction reads rt
- ex_load  in  1  instruction in E is a load
- ex_rd  in  5  destination register of the E instruction
- id_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- ex_md_start  in  1  E instruction starts mult/div this cycle
- ex_md_div  in  1  qualifies ex_md_start: 1 = divide, 0 = multiply
- m_exc  in  1  exception or interrupt recognised in M
- m_exc_code  in  5  ExcCode of that exception
- m_eret  in  1  ERET in M
- epc  in  32  current CP0 EPC
- freeze_pc  out  1  hold PC
- freeze_ifid  out  1  hold IF/ID (its FREEZE input)
- bubble_idex  out  1  clear ID/EX (insert NOP)
- flush_pipe  out  1  clear IF/ID, ID/EX and EX/MEM
- pc_redirect  out  1  load PC from redirect_target
- redirect_target  out  32  HANDLER_ADDR or saved EPC
- md_busy  out  1  multiply/divide unit busy
- exc_code_q  out  5  ExcCode latched at exception entry

Behaviour:
- Reset, asynchronous on reset==0:
  - FSM = RUN; md counter = 0; exc_code_q = 0; saved target = 0.
  - All outputs are 0 while reset is held.
  - Reset asserted mid-FLUSH or mid-busy aborts immediately to RUN with counter 0.
- FSM states: RUN, FLUSH, REFILL.
  - RUN, m_exc=1: next state FLUSH; latch exc_code_q <= m_exc_code; target <= HANDLER_ADDR.
  - RUN, m_eret=1 and m_exc=0: next state FLUSH; target <= epc; exc_code_q unchanged.
  - m_exc and m_eret both 1: exception wins.
  - FLUSH (exactly 1 cycle): flush_pipe=1, pc_redirect=1, redirect_target=target; next state REFILL.
  - REFILL (exactly 1 cycle): m_exc/m_eret ignored, since the bubbles cannot raise them; all stalls still evaluated; next state RUN.
- md counter:
  - On ex_md_start while counter == 0: load MULT_CYCLES or DIV_CYCLES.
  - Otherwise decrement toward 0 each cycle.
  - md_busy = (counter != 0).
  - ex_md_start while busy is a protocol violation; the stall below prevents it, and the counter ignores it.
  - The counter keeps running through FLUSH/REFILL: an issued operation completes.
- Stalls (combinational, outputs are registers-free):
  - Load-use: ex_load & ex_rd != 0 & ((id_rs_use & id_rs == ex_rd) | (id_rt_use & id_rt == ex_rd)).
  - MD: id_md_use & (md_busy | ex_md_start).
  - stall = load-use | MD.
  - stall drives freeze_pc = freeze_ifid = bubble_idex = 1.
- Priority:
  - In FLUSH, stall outputs are forced to 0; the flush overrides the freeze.
  - In RUN, an exception/ERET does not suppress stall in the detection cycle; the flush follows next cycle.
- Latency:
  - Exception detection to redirect: 1 cycle.
  - Redirect to normal issue: 1 cycle.
- Sequence example: MULT in E at cycle t gives md_busy=1 for cycles t+1..t+MULT_CYCLES. A dependent mflo in D stalls in cycles t..t+MULT_CYCLES and advances at t+MULT_CYCLES+1.

Test Plan:
- Load-use: lw $8 in E (ex_load=1, ex_rd=8), D reads rs=8 -> freeze_pc=freeze_ifid=bubble_idex=1 for exactly 1 cycle. Same with ex_rd=0 -> no stall.
- Mult stall: ex_md_start=1, ex_md_div=0, mflo in D -> stall for 6 consecutive cycles, md_busy high for 5. With div -> stall 11 cycles, md_busy high 10.
- Exception: m_exc=1, m_exc_code=12 in RUN -> next cycle flush_pipe=1, pc_redirect=1, redirect_target=0x4180, exc_code_q=12; then REFILL; then RUN. A m_exc pulse in REFILL is ignored.
- ERET: epc=0x3010, m_eret=1 -> next cycle redirect_target=0x3010, exc_code_q unchanged. Simultaneous m_exc=1 -> target 0x4180.
- Overlap: exception while md_busy with mflo stalled in D -> FLUSH cycle shows stall outputs 0 and counter still decrementing; md_busy clears on schedule.
- Reset mid-operation: drive reset=0 during FLUSH with counter=7 -> all outputs 0 immediately without a clock edge. After release: state RUN, md_busy=0.
